// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan channel multiplexer.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Channel index width; a 1-channel corner still needs one index bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Parallel-source / serial-consumer bundle of the channel multiplexer.
interface mux_scan_if
    import mux_pkg::*;
#(
    parameter int CH = 8,
    parameter int W  = 1
);
    localparam int SW = idx_w(CH);

    logic            mode;
    logic [SW-1:0]   sel;
    logic [CH*W-1:0] d;
    logic [CH-1:0]   en_mask;
    logic            start;
    logic [W-1:0]    out;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            frame_done;
    logic            busy;

    modport master (
        output mode, sel, d, en_mask, start,
        input  out, out_ch, out_valid, frame_done, busy
    );

    modport slave (
        input  mode, sel, d, en_mask, start,
        output out, out_ch, out_valid, frame_done, busy
    );
endinterface

// File: rtl/mux_scan_next_ch.sv
// Combinational channel finder: next enabled index above cur, lowest enabled
// index, and whether that next index is the highest enabled one.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter int CH = 8,
    localparam int SW = idx_w(CH)
) (
    input  logic [CH-1:0] mask,
    input  logic [SW-1:0] cur,
    output logic [SW-1:0] nxt,
    output logic          found,
    output logic [SW-1:0] lo,
    output logic          is_last
);
    logic above;

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        lo    = '0;
        above = 1'b0;
        // Descending sweeps so the lowest qualifying index wins.
        for (int i = CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt   = SW'(i);
                found = 1'b1;
            end
            if (mask[i]) begin
                lo = SW'(i);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (mask[i] && (i > int'(nxt))) begin
                above = 1'b1;
            end
        end
        is_last = found && !above;
    end
endmodule

// File: rtl/mux_scan.sv
// Registered N-channel W-bit mux with direct select and masked auto-scan.
module mux_scan
    import mux_pkg::*;
#(
    parameter int CH = 8,
    parameter int W  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.slave  bus
);
    localparam int SW = idx_w(CH);

    state_t        state_q, state_d;
    logic [CH-1:0] mask_q, mask_d;
    logic [W-1:0]  out_q, out_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;

    logic [CH-1:0] find_mask;
    logic [SW-1:0] nxt_ch, lo_ch;
    logic          nxt_found, nxt_last, single_ch;

    // Out-of-range indices (non-power-of-2 CH) select a zero word.
    function automatic logic [W-1:0] pick(input logic [CH*W-1:0] dv,
                                          input logic [SW-1:0]   idx);
        pick = '0;
        for (int k = 0; k < CH; k++) begin
            if (int'(idx) == k) begin
                pick = dv[k*W +: W];
            end
        end
    endfunction

    // In IDLE the finder looks at the live mask so a start can emit at once.
    assign find_mask = (state_q == SCAN) ? mask_q : bus.en_mask;
    assign single_ch = ((bus.en_mask & (bus.en_mask - CH'(1))) == '0);

    mux_next_ch #(.CH(CH)) u_next (
        .mask    (find_mask),
        .cur     (out_ch_q),
        .nxt     (nxt_ch),
        .found   (nxt_found),
        .lo      (lo_ch),
        .is_last (nxt_last)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        out_d        = out_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mode == MODE_DIRECT) begin
                    out_d       = pick(bus.d, bus.sel);
                    out_ch_d    = bus.sel;
                    out_valid_d = 1'b1;
                end else if (bus.start) begin
                    mask_d = bus.en_mask;
                    if (bus.en_mask == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        out_d       = pick(bus.d, lo_ch);
                        out_ch_d    = lo_ch;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        if (single_ch) begin
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = SCAN;
                        end
                    end
                end
            end
            SCAN: begin
                out_d       = pick(bus.d, nxt_ch);
                out_ch_d    = nxt_ch;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                if (nxt_last || !nxt_found) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            out_q        <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            out_q        <= out_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan with CH=8, W=4; channel k carries word k+3.
module tb_mux_scan;
    logic clk;
    logic rst_n;

    mux_scan_if #(.CH(8), .W(4)) bus ();

    mux_scan #(.CH(8), .W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] o;
        logic [2:0] c;
        logic       v;
        logic       fd;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t wexp(input int ch, input bit fd, input bit b);
        exp_t e;
        e.o  = 4'(ch + 3);
        e.c  = 3'(ch);
        e.v  = 1'b1;
        e.fd = fd;
        e.b  = b;
        return e;
    endfunction

    function automatic exp_t nexp(input int o, input int c, input bit fd);
        exp_t e;
        e.o  = 4'(o);
        e.c  = 3'(c);
        e.v  = 1'b0;
        e.fd = fd;
        e.b  = 1'b0;
        return e;
    endfunction

    task automatic drv(input logic m, input logic [2:0] s, input logic [7:0] msk,
                       input logic st, input exp_t e);
        @(negedge clk);
        bus.mode    = m;
        bus.sel     = s;
        bus.en_mask = msk;
        bus.start   = st;
        sb.push_back(e);
    endtask

    // Each pushed entry is the expected output after the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out",        32'(bus.out),        32'(e.o));
                check("out_ch",     32'(bus.out_ch),     32'(e.c));
                check("out_valid",  32'(bus.out_valid),  32'(e.v));
                check("frame_done", 32'(bus.frame_done), 32'(e.fd));
                check("busy",       32'(bus.busy),       32'(e.b));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_out"},   32'(bus.out),        0);
        check({tag, "_ch"},    32'(bus.out_ch),     0);
        check({tag, "_valid"}, 32'(bus.out_valid),  0);
        check({tag, "_fd"},    32'(bus.frame_done), 0);
        check({tag, "_busy"},  32'(bus.busy),       0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.mode    = 1'b1;
        bus.sel     = '0;
        bus.en_mask = '0;
        bus.start   = 1'b0;
        for (int k = 0; k < 8; k++) bus.d[k*4 +: 4] = 4'(k + 3);
        #12;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Scan mode without start stays silent.
        for (int i = 0; i < 3; i++) drv(1'b1, 3'd0, 8'h00, 1'b0, nexp(0, 0, 1'b0));

        // Direct sweep; start at sel=4 must be ignored.
        for (int s = 0; s < 8; s++) drv(1'b0, 3'(s), 8'hFF, (s == 4), wexp(s, 1'b0, 1'b0));

        // Full scan.
        drv(1'b1, 3'd0, 8'hFF, 1'b1, wexp(0, 1'b0, 1'b1));
        for (int k = 1; k < 8; k++) drv(1'b1, 3'd0, 8'hFF, 1'b0, wexp(k, (k == 7), 1'b1));
        drv(1'b1, 3'd0, 8'hFF, 1'b0, nexp(10, 7, 1'b0));

        // Sparse mask with mid-frame mask/mode/sel changes.
        drv(1'b1, 3'd0, 8'b1010_0010, 1'b1, wexp(1, 1'b0, 1'b1));
        drv(1'b0, 3'd3, 8'hFF, 1'b0, wexp(5, 1'b0, 1'b1));
        drv(1'b0, 3'd0, 8'h01, 1'b0, wexp(7, 1'b1, 1'b1));
        drv(1'b1, 3'd0, 8'h00, 1'b0, nexp(10, 7, 1'b0));

        // Empty mask, then single-channel mask.
        drv(1'b1, 3'd0, 8'h00, 1'b1, nexp(10, 7, 1'b1));
        drv(1'b1, 3'd0, 8'h00, 1'b0, nexp(10, 7, 1'b0));
        drv(1'b1, 3'd0, 8'h10, 1'b1, wexp(4, 1'b1, 1'b1));
        drv(1'b1, 3'd0, 8'h10, 1'b0, nexp(7, 4, 1'b0));

        // Back-to-back frames; a mid-frame start is ignored.
        drv(1'b1, 3'd0, 8'hFF, 1'b1, wexp(0, 1'b0, 1'b1));
        for (int k = 1; k < 8; k++) drv(1'b0, 3'(k), 8'h03, (k == 3), wexp(k, (k == 7), 1'b1));
        drv(1'b1, 3'd0, 8'h03, 1'b1, wexp(0, 1'b0, 1'b1));
        drv(1'b1, 3'd0, 8'hFF, 1'b0, wexp(1, 1'b1, 1'b1));
        drv(1'b0, 3'd2, 8'hFF, 1'b0, wexp(2, 1'b0, 1'b0));

        // Reset in the middle of a frame.
        drv(1'b1, 3'd0, 8'hFF, 1'b1, wexp(0, 1'b0, 1'b1));
        drv(1'b1, 3'd0, 8'hFF, 1'b0, wexp(1, 1'b0, 1'b1));
        drv(1'b1, 3'd0, 8'hFF, 1'b0, wexp(2, 1'b0, 1'b1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 3'd0, 8'hFF, 1'b0, nexp(0, 0, 1'b0));
        drv(1'b1, 3'd0, 8'hFF, 1'b0, nexp(0, 0, 1'b0));

        @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
